// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
// One digit is shown per scan slot, and each slot opens with a few blanking cycles.
// Display writes are double-buffered and committed at frame end so a frame never tears.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_wr_en,
    input  logic [4*NUM_DIGITS-1:0] i_wr_data,
    input  logic                    i_lz_blank,
    output logic [3:0]              o_nibble,
    input  logic [6:0]              i_seg,
    output logic [6:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_pending,
    output logic                    o_frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] AN_ONE = 1;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    state_t                state_q, state_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  fd_q, fd_d;
    logic                  slot_end, frame_end, suppress;

    // Shared decoder is fed straight from the committed value and current digit.
    assign o_nibble = disp_q[4*idx_q +: 4];

    // Next-state computation: scan position, buffered value and output drive.
    always_comb begin
        slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
        frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
        // A digit is a leading zero when it and every more-significant digit are zero.
        suppress  = i_lz_blank && (idx_q != '0) && ((disp_q >> (4*idx_q)) == '0);

        cnt_d     = '0;
        idx_d     = '0;
        state_d   = ST_BLANK;
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        an_d      = '1;
        seg_d     = 7'h7F;
        fd_d      = 1'b0;

        if (i_enable) begin
            cnt_d = slot_end ? '0 : cnt_q + 1'b1;
            idx_d = idx_q;
            if (slot_end)
                idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            state_d = (cnt_d < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;

            // A write landing on the frame-end edge is forwarded and beats the shadow.
            if (i_wr_en && frame_end) begin
                disp_d    = i_wr_data;
                pending_d = 1'b0;
            end else if (i_wr_en) begin
                shadow_d  = i_wr_data;
                pending_d = 1'b1;
            end else if (frame_end && pending_q) begin
                disp_d    = shadow_q;
                pending_d = 1'b0;
            end

            if (state_q == ST_SHOW && !suppress) begin
                an_d  = ~(AN_ONE << idx_q);
                seg_d = i_seg;
            end
            fd_d = frame_end;
        end else begin
            // Nothing is on screen, so writes take effect at once.
            if (i_wr_en)
                disp_d = i_wr_data;
            shadow_d  = '0;
            pending_d = 1'b0;
        end
    end

    // Single state register for scan position, buffers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            state_q   <= ST_BLANK;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            seg_q     <= 7'h7F;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            fd_q      <= fd_d;
        end
    end

    assign o_an         = an_q;
    assign o_seg        = seg_q;
    assign o_pending    = pending_q;
    assign o_frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed scenarios plus a randomized phase,
// all checked every cycle against a frame-position reference model.
module tb_seg_scan_controller;
    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam int FR  = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, en = 1'b0, wr = 1'b0, lz = 1'b0;
    logic [15:0] wdata = '0;
    logic [3:0]  nib, an;
    logic [6:0]  seg_in, seg;
    logic        pend, fd;

    int checks = 0, failures = 0;

    // Reference state: position within the frame plus buffered values.
    int          m_pos = 0;
    logic [15:0] m_disp = '0, m_shadow = '0;
    logic        m_pend = 1'b0, e_fd = 1'b0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;

    logic [3:0] an_t [4];
    logic [6:0] seg_t[4];

    always #5 clk = ~clk;

    seg_scan_controller #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_wr_en(wr), .i_wr_data(wdata),
        .i_lz_blank(lz), .o_nibble(nib), .i_seg(seg_in), .o_seg(seg), .o_an(an),
        .o_pending(pend), .o_frame_done(fd)
    );

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0100000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    always_comb seg_in = hex7(nib);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference by one clock edge using the inputs now applied.
    task automatic model_edge();
        int  d, c;
        logic lit;
        if (!rst_n) begin
            m_pos = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
        end else if (!en) begin
            m_pos = 0;
            if (wr) m_disp = wdata;
            m_shadow = '0; m_pend = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
        end else begin
            d = m_pos / DIV;
            c = m_pos % DIV;
            lit   = (c >= BLK) && !(lz && d > 0 && (m_disp >> (4*d)) == 0);
            e_an  = lit ? ~(4'b0001 << d) : 4'hF;
            e_seg = lit ? hex7(m_disp[4*d +: 4]) : 7'h7F;
            e_fd  = (m_pos == FR - 1);
            if (wr && e_fd) begin
                m_disp = wdata; m_pend = 1'b0;
            end else if (wr) begin
                m_shadow = wdata; m_pend = 1'b1;
            end else if (e_fd && m_pend) begin
                m_disp = m_shadow; m_pend = 1'b0;
            end
            m_pos = (m_pos + 1) % FR;
        end
    endtask

    // One clock: update reference, sample DUT 1 time unit after the edge, drop write strobe.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("pending", pend, m_pend);
        chk("frame_done", fd, e_fd);
        chk("nibble", nib, m_disp[4*(m_pos/DIV) +: 4]);
        wr = 1'b0;
    endtask

    task automatic run_to(input int p);
        for (int k = 0; k < FR && m_pos != p; k++) cyc();
    endtask

    initial begin
        an_t[0] = 4'b1110;  an_t[1] = 4'b1101;  an_t[2] = 4'b1011;  an_t[3] = 4'b0111;
        seg_t[0] = 7'b0011001; seg_t[1] = 7'b0100000; seg_t[2] = 7'b0100100; seg_t[3] = 7'b1111001;

        // Reset mid-scan with a write pending
        rst_n = 1'b0; en = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1; en = 1'b1; wdata = 16'h3333; wr = 1'b1;
        cyc();
        repeat (5) cyc();
        chk("t1_pend_set", pend, 1);
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("t1_rst_an", an, 4'hF);
        chk("t1_rst_seg", seg, 7'h7F);
        chk("t1_rst_pend", pend, 0);
        chk("t1_rst_nib", nib, 0);
        rst_n = 1'b1;
        cyc(); cyc();
        chk("t1_blank_an", an, 4'hF);
        cyc();
        chk("t1_first_an", an, 4'b1110);
        chk("t1_first_seg", seg, 7'b1000000);

        // Write while disabled, then scan one full frame
        en = 1'b0; wdata = 16'h12A4; wr = 1'b1;
        cyc();
        en = 1'b1;
        for (int s = 0; s < N; s++)
            for (int c = 0; c < DIV; c++) begin
                cyc();
                if (c == 0) chk("t2_blank_an", an, 4'hF);
                if (c == 2) begin
                    chk("t2_an", an, an_t[s]);
                    chk("t2_seg", seg, seg_t[s]);
                end
            end

        // Tear-free commit
        run_to(DIV + 3);
        wdata = 16'h0005; wr = 1'b1;
        cyc();
        chk("t3_pending", pend, 1);
        run_to(2*DIV + 2);
        cyc();
        chk("t3_slot2_seg", seg, 7'b0100100);
        run_to(3*DIV + 2);
        cyc();
        chk("t3_slot3_seg", seg, 7'b1111001);
        run_to(FR - 1);
        cyc();
        chk("t3_frame_done", fd, 1);
        chk("t3_pend_clr", pend, 0);
        chk("t3_nib", nib, 4'h5);
        repeat (3) cyc();
        chk("t3_new_seg", seg, 7'b0010010);

        // Leading-zero suppression
        run_to(0);
        en = 1'b0; wdata = 16'h0050; wr = 1'b1;
        cyc();
        en = 1'b1; lz = 1'b1;
        for (int s = 0; s < N; s++)
            for (int c = 0; c < DIV; c++) begin
                cyc();
                if (c == 2 && s >= 2) chk("t4_dark_an", an, 4'hF);
                if (c == 2 && s == 1) chk("t4_s1_seg", seg, 7'b0010010);
                if (c == 2 && s == 0) chk("t4_s0_seg", seg, 7'b1000000);
            end
        en = 1'b0; wdata = 16'h0000; wr = 1'b1;
        cyc();
        en = 1'b1;
        for (int s = 0; s < N; s++)
            for (int c = 0; c < DIV; c++) begin
                cyc();
                if (c == 2) chk("t4_zero_an", an, (s == 0) ? 4'b1110 : 4'hF);
            end

        // Frame-end forwarding and last-write-wins
        lz = 1'b0;
        run_to(10);
        wdata = 16'h1111; wr = 1'b1;
        cyc();
        run_to(FR - 1);
        wdata = 16'hBEEF; wr = 1'b1;
        cyc();
        chk("t5_fwd_pend", pend, 0);
        chk("t5_fwd_fd", fd, 1);
        chk("t5_fwd_nib", nib, 4'hF);
        run_to(2);
        cyc();
        chk("t5_beef_seg", seg, 7'b0001110);
        run_to(5);
        wdata = 16'h1111; wr = 1'b1;
        cyc();
        run_to(12);
        wdata = 16'h2222; wr = 1'b1;
        cyc();
        run_to(FR - 1);
        cyc();
        chk("t5_last_nib", nib, 4'h2);
        run_to(2);
        cyc();
        chk("t5_last_seg", seg, 7'b0100100);

        // Mid-frame disable and re-enable
        run_to(2*DIV + 3);
        en = 1'b0;
        cyc();
        chk("t6_off_an", an, 4'hF);
        chk("t6_off_fd", fd, 0);
        repeat (3) cyc();
        en = 1'b1;
        cyc(); cyc();
        chk("t6_re_blank", an, 4'hF);
        cyc();
        chk("t6_re_an", an, 4'b1110);

        // Randomized phase against the reference
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom % 150) != 0;
            if ($urandom % 40 == 0) en = ~en;
            if ($urandom % 20 == 0) lz = ~lz;
            wr    = ($urandom % 12) == 0;
            wdata = ($urandom % 2) ? 16'($urandom) : 16'($urandom % 256);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
